rv_alu_md: RTL and testbench

RV_ALU_MD -- requirements
Module: rv_alu_md

---
 rtl/rv_alu_md.sv | 168 ++++++++++++++++
 tb/tb_rv_alu_md.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rv_alu_md.sv
`timescale 1ns/1ps
// rv_alu_md: RISC-V base ALU plus M-extension multiply/divide, one request in flight.
// Latency: 1 cycle for base ops and divide special cases, XLEN+1 for iterative mul/div (mul 1 with RV_ALU_MD_FAST_MUL_EN).
// Backpressure: o_ready only while idle; result held until i_ready; i_flush aborts any state.
module rv_alu_md #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [4:0]      i_op,
    input  logic [XLEN-1:0] i_src_a,
    input  logic [XLEN-1:0] i_src_b,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [2:0]         m_op;
    logic               neg;
    logic [XLEN-1:0]    acc, lo, opnd, result;
    logic [SHAMT_W-1:0] cnt;

    logic [2:0]         f3;
    logic               is_m, a_signed, b_signed, a_neg, b_neg, res_neg;
    logic               div_zero, div_ovf, go_calc;
    logic [XLEN-1:0]    mag_a, mag_b, base_res, imm_res;
    logic [SHAMT_W-1:0] shamt;

    assign f3       = i_op[2:0];
    assign is_m     = i_op[4];
    assign shamt    = i_src_b[SHAMT_W-1:0];
    assign a_signed = is_m && (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd6);
    assign b_signed = is_m && (f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd6);
    assign a_neg    = a_signed && i_src_a[XLEN-1];
    assign b_neg    = b_signed && i_src_b[XLEN-1];
    assign mag_a    = a_neg ? -i_src_a : i_src_a;
    assign mag_b    = b_neg ? -i_src_b : i_src_b;
    // remainder takes the dividend's sign; everything else the xor of operand signs
    assign res_neg  = (f3[2] && f3[1]) ? a_neg : (a_neg ^ b_neg);
    assign div_zero = (i_src_b == '0);
    assign div_ovf  = !f3[0] && (i_src_a == {1'b1, {(XLEN-1){1'b0}}}) && (&i_src_b);

    always_comb begin
        base_res = '0;
        case (i_op[3:0])
            4'd0: base_res = i_src_a + i_src_b;
            4'd1: base_res = i_src_a - i_src_b;
            4'd2: base_res = i_src_a << shamt;
            4'd3: base_res = XLEN'($signed(i_src_a) < $signed(i_src_b));
            4'd4: base_res = XLEN'(i_src_a < i_src_b);
            4'd5: base_res = i_src_a ^ i_src_b;
            4'd6: base_res = i_src_a >> shamt;
            4'd7: base_res = $unsigned($signed(i_src_a) >>> shamt);
            4'd8: base_res = i_src_a | i_src_b;
            4'd9: base_res = i_src_a & i_src_b;
            default: base_res = '0;
        endcase
    end

`ifdef RV_ALU_MD_FAST_MUL_EN
    logic signed [2*XLEN+1:0] fast_a, fast_b, fast_p;
    assign fast_a = (2*XLEN+2)'($signed({a_signed & i_src_a[XLEN-1], i_src_a}));
    assign fast_b = (2*XLEN+2)'($signed({b_signed & i_src_b[XLEN-1], i_src_b}));
    assign fast_p = fast_a * fast_b;
`endif

    always_comb begin
        go_calc = 1'b0;
        imm_res = base_res;
        if (is_m) begin
            if (f3[2]) begin
                if (div_zero)     imm_res = f3[1] ? i_src_a : '1;
                else if (div_ovf) imm_res = f3[1] ? '0 : i_src_a;
                else              go_calc = 1'b1;
            end else begin
`ifdef RV_ALU_MD_FAST_MUL_EN
                imm_res = (f3[1:0] == 2'd0) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
`else
                go_calc = 1'b1;
`endif
            end
        end
    end

    // one radix-2 step: shift-add for multiply, restoring subtract for divide
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]   step_acc, step_lo, fin_res;
    logic [2*XLEN-1:0] prod, prod_s;

    always_comb begin
        mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (m_op[2]) begin
            if (!div_diff[XLEN]) begin
                step_acc = div_diff[XLEN-1:0];
                step_lo  = {lo[XLEN-2:0], 1'b1};
            end else begin
                step_acc = div_shift[XLEN-1:0];
                step_lo  = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            step_acc = mul_sum[XLEN:1];
            step_lo  = {mul_sum[0], lo[XLEN-1:1]};
        end
        prod   = {step_acc, step_lo};
        prod_s = neg ? -prod : prod;
        if (m_op[2])
            fin_res = m_op[1] ? (neg ? -step_acc : step_acc) : (neg ? -step_lo : step_lo);
        else
            fin_res = (m_op[1:0] == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state  <= IDLE;
            m_op   <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            lo     <= '0;
            opnd   <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (i_flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (i_valid) begin
                    m_op <= f3;
                    neg  <= res_neg;
                    acc  <= '0;
                    cnt  <= SHAMT_W'(XLEN-1);
                    lo   <= f3[2] ? mag_a : mag_b;
                    opnd <= f3[2] ? mag_b : mag_a;
                    if (go_calc) begin
                        state <= CALC;
                    end else begin
                        result <= imm_res;
                        state  <= DONE;
                    end
                end
                CALC: begin
                    acc <= step_acc;
                    lo  <= step_lo;
                    cnt <= cnt - SHAMT_W'(1);
                    if (cnt == '0) begin
                        result <= fin_res;
                        state  <= DONE;
                    end
                end
                DONE: if (i_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign o_ready  = (state == IDLE);
    assign o_valid  = (state == DONE);
    assign o_result = result;
    assign o_zero   = (result == '0);
endmodule

// File: tb/tb_rv_alu_md.sv
`timescale 1ns/1ps
// Randomized and directed bench for rv_alu_md (XLEN=32) against a plain-arithmetic reference model.
module tb_rv_alu_md;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0, i_flush = 1'b0, i_ready = 1'b1;
    logic [4:0]  i_op = '0;
    logic [31:0] i_src_a = '0, i_src_b = '0;
    logic        o_ready, o_valid, o_zero;
    logic [31:0] o_result;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] MIN_INT = 32'h8000_0000;

    rv_alu_md #(.XLEN(32)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_src_a(i_src_a), .i_src_b(i_src_b), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_zero(o_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        if (!op[4]) begin
            case (op[3:0])
                4'd0: return a + b;
                4'd1: return a - b;
                4'd2: return a << b[4:0];
                4'd3: return {31'b0, sa < sb};
                4'd4: return {31'b0, a < b};
                4'd5: return a ^ b;
                4'd6: return a >> b[4:0];
                4'd7: begin p = 64'(sa >>> b[4:0]); return p[31:0]; end
                4'd8: return a | b;
                4'd9: return a & b;
                default: return 32'd0;
            endcase
        end
        case (op[2:0])
            3'd0: begin p = 64'(ua * ub); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_INT && b == 32'hFFFF_FFFF) return a;
                p = 64'(sa / sb); return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'd0;
                p = 64'(sa % sb); return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[4]) return 1;
        if (!op[2]) begin
`ifdef RV_ALU_MD_FAST_MUL_EN
            return 1;
`else
            return 33;
`endif
        end
        if (b == 0) return 1;
        if (!op[0] && a == MIN_INT && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
        logic [31:0] exp;
        int          lat, cyc;
        exp = model(op, a, b);
        lat = model_lat(op, a, b);
        @(negedge clk);
        chk({tag, "_rdy_in"}, o_ready, 1'b1);
        i_valid = 1'b1; i_op = op; i_src_a = a; i_src_b = b;
        i_ready = (hold == 0);
        @(posedge clk); #1;
        i_valid = 1'b0;
        cyc = 1;
        while (!o_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_lat"}, cyc, lat);
        chk({tag, "_res"}, o_result, exp);
        chk({tag, "_zero"}, o_zero, exp == 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_vld"}, o_valid, 1'b1);
            chk({tag, "_hold_res"}, o_result, exp);
            chk({tag, "_hold_rdy"}, o_ready, 1'b0);
        end
        i_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_ret_rdy"}, o_ready, 1'b1);
        chk({tag, "_ret_vld"}, o_valid, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return MIN_INT;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // starts a long op, then aborts it at cycle 10 with either flush or reset
    task automatic abort_test(input string tag, input bit use_reset);
        int rises;
        @(negedge clk);
        i_valid = 1'b1;
`ifdef RV_ALU_MD_FAST_MUL_EN
        i_op = 5'b10101;
`else
        i_op = 5'b10000;
`endif
        i_src_a = 32'd1234; i_src_b = 32'd77;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        if (use_reset) begin
            rst_n = 1'b0;
            #1;
            chk({tag, "_async_rdy"}, o_ready, 1'b1);
            chk({tag, "_async_res"}, o_result, 32'd0);
            #1 rst_n = 1'b1;
        end else begin
            i_flush = 1'b1;
        end
        @(posedge clk); #1;
        i_flush = 1'b0;
        chk({tag, "_rdy"}, o_ready, 1'b1);
        chk({tag, "_vld"}, o_valid, 1'b0);
        rises = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (o_valid) rises++;
        end
        chk({tag, "_no_result"}, rises, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [4:0] rop;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", o_ready, 1'b1);
        chk("rst_vld", o_valid, 1'b0);
        chk("rst_res", o_result, 32'd0);
        chk("rst_zero", o_zero, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("sub",    5'b00001, 32'd5, 32'd7, 0);
        do_op("mulh",   5'b10001, MIN_INT, MIN_INT, 0);
        do_op("div",    5'b10100, 32'hFFFF_FFF9, 32'd2, 0);
        do_op("rem",    5'b10110, 32'hFFFF_FFF9, 32'd2, 0);
        do_op("divu0",  5'b10101, 32'd9, 32'd0, 0);
        do_op("remu0",  5'b10111, 32'd9, 32'd0, 0);
        do_op("divovf", 5'b10100, MIN_INT, 32'hFFFF_FFFF, 0);
        do_op("removf", 5'b11110, MIN_INT, 32'hFFFF_FFFF, 0);
        do_op("divu_h", 5'b10101, 32'd100, 32'd7, 5);
        do_op("mulhsu", 5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op("sra",    5'b00111, MIN_INT, 32'd35, 0);
        do_op("op12",   5'b01100, 32'd3, 32'd4, 0);

        // a request alongside flush must not be taken
        @(negedge clk);
        i_valid = 1'b1; i_flush = 1'b1; i_op = 5'b00000; i_src_a = 32'd1; i_src_b = 32'd1;
        @(posedge clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        chk("vflush_rdy", o_ready, 1'b1);
        @(posedge clk); #1;
        chk("vflush_vld", o_valid, 1'b0);

        abort_test("flush", 1'b0);
        abort_test("reset", 1'b1);
        do_op("post_rst", 5'b10011, 32'hDEAD_BEEF, 32'h1234_5678, 0);

        for (int i = 0; i < 60; i++) begin
            rop = 5'($urandom_range(0, 31));
            do_op("rnd", rop, pick(), pick(), (i % 7 == 3) ? 2 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
